// File: rtl/switch_log_writer.sv
// Port-B bus master that debounces the switch inputs and appends each accepted
// change as {seq, value} to a circular buffer in data memory for the CPU to poll.
module switch_log_writer #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BUF_BASE   = 16'h6000,
    parameter int                    PTR_WIDTH  = 4,
    parameter int                    DEBOUNCE   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            switches,
    input  logic                  enable,
    input  logic [PTR_WIDTH-1:0]  tail_ptr,
    input  logic                  clr_overflow,
    output logic [ADDR_WIDTH-1:0] address_b,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic                  wren_b,
    output logic [PTR_WIDTH-1:0]  head_ptr,
    output logic [PTR_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  overflow
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {IDLE, WATCH, WRITE} state_t;

    state_t         state, state_next;
    logic [7:0]     sync1, sync2, sync3;
    logic [7:0]     accepted;
    logic [7:0]     pend_val;
    logic [7:0]     evt_val;
    logic [7:0]     seq;
    logic [CW-1:0]  deb_cnt;
    logic           pend, pend_next;
    logic           stable_diff, accept_now;
    logic           evt_valid, do_write, do_drop;

    assign stable_diff = (sync2 == sync3) && (sync2 != accepted);
    assign accept_now  = stable_diff && (deb_cnt == DEB_LAST) && (state != IDLE);

    assign count = head_ptr - tail_ptr;
    assign full  = (head_ptr + PTR_WIDTH'(1)) == tail_ptr;

    // An event accepted during WRITE is parked in pend and served from WATCH.
    always_comb begin
        state_next = state;
        pend_next  = pend;
        do_write   = 1'b0;
        do_drop    = 1'b0;
        evt_valid  = pend | accept_now;
        evt_val    = pend ? pend_val : sync2;
        case (state)
            IDLE: begin
                pend_next = 1'b0;
                if (enable) state_next = WATCH;
            end
            WATCH: begin
                if (!enable) begin
                    state_next = IDLE;
                    pend_next  = 1'b0;
                end else begin
                    pend_next = pend & accept_now;
                    if (evt_valid) begin
                        if (full) begin
                            do_drop = 1'b1;
                        end else begin
                            do_write   = 1'b1;
                            state_next = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                state_next = enable ? WATCH : IDLE;
                pend_next  = enable & (pend | accept_now);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            sync1     <= '0;
            sync2     <= '0;
            sync3     <= '0;
            accepted  <= '0;
            deb_cnt   <= '0;
            pend      <= 1'b0;
            pend_val  <= '0;
            seq       <= '0;
            head_ptr  <= '0;
            overflow  <= 1'b0;
            wren_b    <= 1'b0;
            address_b <= BUF_BASE;
            data_b    <= '0;
        end else begin
            state <= state_next;
            pend  <= pend_next;
            sync1 <= switches;
            sync2 <= sync1;
            sync3 <= sync2;

            if (pend_next && accept_now) pend_val <= sync2;

            if (state == IDLE || !stable_diff || accept_now || (state == WATCH && !enable))
                deb_cnt <= '0;
            else
                deb_cnt <= deb_cnt + CW'(1);

            // Entering WATCH takes the current switch word as baseline, not as a change.
            if ((state == IDLE && enable) || accept_now) accepted <= sync2;

            wren_b <= do_write;
            if (do_write) begin
                address_b <= BUF_BASE + ADDR_WIDTH'(head_ptr);
                data_b    <= DATA_WIDTH'({seq + 8'd1, evt_val});
            end
            if (do_write || do_drop) seq <= seq + 8'd1;
            if (state == WRITE) head_ptr <= head_ptr + PTR_WIDTH'(1);

            if (do_drop)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;
        end
    end

endmodule
